mux_arb_n: RTL and testbench
============================

MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (1..64).
REQ-002 SHALL have parameter N, default 4, input channel count (2..16).
REQ-003 SHALL have parameter MODE, default 0: 0 = external select, 1 = round-robin arbitration.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(N)).
REQ-005 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-007 SHALL have port in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid  input  N  per-channel valid.
REQ-009 SHALL have port in_ready  output  N  per-channel ready, at most one bit high.
REQ-010 SHALL have port sel  input  SEL_W  channel select, used only when MODE=0.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_valid  output  1  out_data/out_chan hold a word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-014 SHALL have port out_chan  output  SEL_W  source channel index of out_data.

Function
REQ-015 SHALL transfer on an input channel when in_valid[i] and in_ready[i] are both high at a rising edge; output transfer when out_valid and out_ready are both high.
REQ-016 SHALL compute load_en = !out_valid || out_ready (output register empty or draining this cycle).
REQ-017 MODE=0: grant SHALL be channel sel when sel < N and in_valid[sel]=1; otherwise no grant; sel >= N never grants.
REQ-018 MODE=1: grant SHALL be the first channel with in_valid high, searching ptr, ptr+1, ... N-1, 0, ... ptr-1; no grant if in_valid is all zero.
REQ-019 SHALL drive in_ready[g]=1 only for granted channel g and only while load_en=1; all other bits 0; in_ready is combinational from in_valid, sel, ptr, out_valid and out_ready.
REQ-020 On a rising edge with load_en=1 and a grant g: out_data <= data of channel g, out_chan <= g, out_valid <= 1.
REQ-021 On a rising edge with load_en=1 and no grant: out_valid <= 0; out_data and out_chan hold.
REQ-022 With load_en=0, out_data, out_chan and out_valid SHALL hold (stable under backpressure).
REQ-023 Latency SHALL be 1 cycle from input transfer to out_valid; sustained throughput SHALL be 1 word/cycle while out_ready=1.
REQ-024 MODE=1: ptr SHALL update only on an input transfer, to (g+1) mod N, wrapping N-1 -> 0; ptr is unused and held at 0 in MODE=0.
REQ-025 Change of sel or in_valid SHALL take effect in the same cycle's grant; no word is dropped or duplicated, since only handshaken words are loaded.
REQ-026 Words from one channel SHALL leave in acceptance order; no internal storage beyond one output register.

Reset
REQ-027 While rst=1 at a rising edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= 0.
REQ-028 While rst=1, in_ready SHALL be all zero, so no input transfer occurs during reset.
REQ-029 rst SHALL override any handshake in the same cycle; a word held in the output register at reset is discarded.

Verification (N=4, WIDTH=8 unless stated)
REQ-030 Reset: rst=1 for 2 cycles, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0000, out_valid=0, out_data=8'h00, out_chan=0.
REQ-031 MODE=0: sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
REQ-032 Backpressure: out_valid=1 with 8'h3C, out_ready=0 for 3 cycles -> out_data stays 8'h3C, in_ready=4'b0000; out_ready=1 -> next queued word loaded the same edge, no gap.
REQ-033 MODE=1, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-034 MODE=1, in_valid=4'b1010 -> out_chan sequence 1,3,1,3; then in_valid=4'b0000 -> out_valid=0 next cycle.
REQ-035 N=3, MODE=0, sel=3 with in_valid=3'b111 -> in_ready=3'b000, out_valid stays 0; rst pulsed mid-stream in MODE=1 -> out_valid=0 next edge and arbitration restarts at channel 0.

Source files
------------

// File: rtl/mux_arb_n.sv
// N-to-1 registered multiplexer with valid/ready handshakes.
// MODE=0 picks the channel on sel; MODE=1 arbitrates round-robin.
module mux_arb_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_chan
);

    logic [WIDTH-1:0] ch_data [N];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt;
    logic             gnt_vld;
    logic             load_en;
    logic             xfer;
    int               idx;

    assign load_en = !out_valid || out_ready;
    assign xfer    = |in_ready;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign ch_data[i]  = in_data[i*WIDTH +: WIDTH];
        assign in_ready[i] = gnt_vld && load_en && !rst && (gnt == SEL_W'(i));
    end

    // Round-robin scans from the highest offset down so the offset nearest
    // ptr is the last (and winning) assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (32'(sel) == i && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = SEL_W'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = (32'(ptr) + k) % N;
                if (in_valid[SEL_W'(idx)]) begin
                    gnt_vld = 1'b1;
                    gnt     = SEL_W'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load_en) begin
            if (gnt_vld) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[gnt];
                out_chan  <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // ptr only moves on an accepted word; it stays 0 in select mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (MODE == 1 && xfer) begin
            if (gnt == SEL_W'(N - 1)) ptr <= '0;
            else                      ptr <= gnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: three configurations driven from shared stimulus,
// each tracked by a behavioural model of the output register and pointer.
module tb_mux_arb_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] data;
    logic [3:0]  vin;
    logic [1:0]  sel;
    logic        ordy;

    logic [3:0] a_r, b_r;
    logic [2:0] c_r;
    logic [7:0] a_od, b_od, c_od;
    logic       a_ov, b_ov, c_ov;
    logic [1:0] a_oc, b_oc, c_oc;

    mux_arb_n #(.WIDTH(8), .N(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(data), .in_valid(vin), .in_ready(a_r),
        .sel(sel), .out_data(a_od), .out_valid(a_ov), .out_ready(ordy), .out_chan(a_oc));
    mux_arb_n #(.WIDTH(8), .N(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(data), .in_valid(vin), .in_ready(b_r),
        .sel(sel), .out_data(b_od), .out_valid(b_ov), .out_ready(ordy), .out_chan(b_oc));
    mux_arb_n #(.WIDTH(8), .N(3), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .in_data(data[23:0]), .in_valid(vin[2:0]), .in_ready(c_r),
        .sel(sel), .out_data(c_od), .out_valid(c_ov), .out_ready(ordy), .out_chan(c_oc));

    int n_chk = 0;
    int n_fail = 0;
    int nch [3] = '{4, 4, 3};
    int md  [3] = '{0, 1, 0};
    int m_ov [3] = '{0, 0, 0};
    int m_od [3] = '{0, 0, 0};
    int m_oc [3] = '{0, 0, 0};
    int m_ptr[3] = '{0, 0, 0};

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant from the rules: select mode honours sel only if in range and
    // valid; round-robin takes the first valid channel at or after ptr.
    function automatic int grant(input int k);
        if (md[k] == 0) begin
            if (int'(sel) < nch[k] && vin[sel]) return int'(sel);
            return -1;
        end
        for (int i = 0; i < nch[k]; i++) begin
            int c;
            c = (m_ptr[k] + i) % nch[k];
            if (vin[c]) return c;
        end
        return -1;
    endfunction

    function automatic int rdy_of(input int k);
        case (k)
            0: return int'(a_r);
            1: return int'(b_r);
            default: return int'(c_r);
        endcase
    endfunction

    // One clock: check ready mid-cycle, advance the model, check outputs.
    task automatic cyc();
        int nov[3], nod[3], noc[3], np[3];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            int g, le, er;
            g  = grant(k);
            le = (m_ov[k] == 0 || ordy) ? 1 : 0;
            er = (rst || le == 0 || g < 0) ? 0 : (1 << g);
            chk($sformatf("ready%0d", k), rdy_of(k), er);
            nov[k] = m_ov[k]; nod[k] = m_od[k]; noc[k] = m_oc[k]; np[k] = m_ptr[k];
            if (rst) begin
                nov[k] = 0; nod[k] = 0; noc[k] = 0; np[k] = 0;
            end else if (le != 0) begin
                if (g >= 0) begin
                    nov[k] = 1;
                    nod[k] = int'(data[g*8 +: 8]);
                    noc[k] = g;
                    if (md[k] == 1) np[k] = (g + 1) % nch[k];
                end else begin
                    nov[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = nov[k]; m_od[k] = nod[k]; m_oc[k] = noc[k]; m_ptr[k] = np[k];
        end
        chk("ov0", int'(a_ov), m_ov[0]); chk("od0", int'(a_od), m_od[0]); chk("oc0", int'(a_oc), m_oc[0]);
        chk("ov1", int'(b_ov), m_ov[1]); chk("od1", int'(b_od), m_od[1]); chk("oc1", int'(b_oc), m_oc[1]);
        chk("ov2", int'(c_ov), m_ov[2]); chk("od2", int'(c_od), m_od[2]); chk("oc2", int'(c_oc), m_oc[2]);
    endtask

    initial begin
        int seq13 [4] = '{1, 3, 1, 3};
        // reset with every channel requesting
        rst = 1'b1; vin = 4'b1111; ordy = 1'b1; sel = 2'd0; data = 32'h44332211;
        #1;
        chk("rst_ready", int'(a_r), 0);
        cyc(); cyc();
        chk("rst_ov", int'(a_ov), 0); chk("rst_od", int'(a_od), 0); chk("rst_oc", int'(a_oc), 0);

        // select mode basic transfer
        rst = 1'b0; sel = 2'd2; vin = 4'b0100; data = 32'h00A50000;
        #1;
        chk("sel_ready", int'(a_r), 4'b0100);
        cyc();
        chk("sel_ov", int'(a_ov), 1); chk("sel_od", int'(a_od), 8'hA5); chk("sel_oc", int'(a_oc), 2);

        // backpressure holds output, no gap when released
        data = 32'h003C0000;
        cyc();
        data = 32'h00770000; ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_od", int'(a_od), 8'h3C);
            chk("bp_ready", int'(a_r), 0);
        end
        ordy = 1'b1;
        #1;
        chk("bp_rel_ready", int'(a_r), 4'b0100);
        cyc();
        chk("bp_rel_od", int'(a_od), 8'h77); chk("bp_rel_ov", int'(a_ov), 1);

        // round-robin, all requesting
        rst = 1'b1; cyc(); rst = 1'b0;
        vin = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_all_oc", int'(b_oc), i % 4);
            chk("rr_all_ov", int'(b_ov), 1);
        end

        // round-robin, sparse requests, then idle
        rst = 1'b1; cyc(); rst = 1'b0;
        vin = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_sparse_oc", int'(b_oc), seq13[i]);
        end
        vin = 4'b0000;
        cyc();
        chk("rr_idle_ov", int'(b_ov), 0);

        // N=3: out-of-range select never grants
        rst = 1'b1; cyc(); rst = 1'b0;
        sel = 2'd3; vin = 4'b0111;
        #1;
        chk("oor_ready", int'(c_r), 0);
        cyc(); cyc();
        chk("oor_ov", int'(c_ov), 0);

        // reset mid-stream restarts arbitration at channel 0
        vin = 4'b1111;
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_ov", int'(b_ov), 0);
        rst = 1'b0;
        cyc();
        chk("mid_rst_oc", int'(b_oc), 0);
        chk("mid_rst_ov1", int'(b_ov), 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            vin  = 4'($urandom);
            sel  = 2'($urandom);
            data = $urandom;
            ordy = ($urandom_range(3) != 0);
            rst  = ($urandom_range(39) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
